fetch_prefetch_unit: RTL and testbench

- Fetch-stage producer feeding the IF/ID pipeline register.
- Issues in-order requests to instruction memory using a req/gnt address handshake and an rvalid data return.
- Buffers returned instructions with their PCs in a small FIFO and presents instrF/pcF/pc_plus4F with a valid flag.
- Honours StallF from the hazard unit. On a taken branch or jump (redirect), it discards in-flight responses and restarts fetch at the target.

---
 rtl/fetch_prefetch_unit.sv | 102 ++++++++++
 tb/tb_fetch_prefetch_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - in-order instruction prefetcher with credit-limited requests and redirect flush
module fetch_prefetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        StallF,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instrF,
  output logic [31:0] pcF,
  output logic [31:0] pc_plus4F,
  output logic        validF
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   fpc;
  logic [31:0]   rpc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] discard;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];

  logic [CW:0] occ;
  logic        fire;
  logic        rv_ok;
  logic        keep;
  logic        pop;

  // A request is only issued when a FIFO slot is reserved for its response.
  always_comb begin
    occ      = {1'b0, count} + {1'b0, inflight};
    imem_req = rst && !redirect && (occ < DEPTH_W);
    fire     = imem_req && imem_gnt;
    rv_ok    = imem_rvalid && (inflight != '0);
    keep     = rv_ok && (discard == '0) && !redirect;
    pop      = validF && !StallF && !redirect;
  end

  assign imem_addr = fpc;
  assign validF    = (count != '0);
  assign instrF    = validF ? instr_q[rd_ptr] : NOP_INSTR;
  assign pcF       = validF ? pc_q[rd_ptr] : 32'h0;
  assign pc_plus4F = pcF + 32'd4;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc      <= RESET_PC;
      rpc      <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (redirect) begin
      fpc      <= redirect_pc;
      rpc      <= redirect_pc;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      inflight <= inflight - CW'(rv_ok);
      // Pending discards are a subset of inflight, so every outstanding response becomes stale.
      discard  <= inflight - CW'(rv_ok);
    end else begin
      if (fire) begin
        fpc <= fpc + 32'd4;
      end
      inflight <= inflight + CW'(fire) - CW'(rv_ok);
      if (keep) begin
        rpc    <= rpc + 32'd4;
        wr_ptr <= wr_ptr + AW'(1);
      end else if (rv_ok && (discard != '0)) begin
        discard <= discard - CW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(keep) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (keep) begin
      instr_q[wr_ptr] <= imem_rdata;
      pc_q[wr_ptr]    <= rpc;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - self-checking bench for fetch_prefetch_unit
module tb_fetch_prefetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        StallF = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] instrF;
  logic [31:0] pcF;
  logic [31:0] pc_plus4F;
  logic        validF;

  fetch_prefetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .StallF(StallF), .redirect(redirect), .redirect_pc(redirect_pc),
    .instrF(instrF), .pcF(pcF), .pc_plus4F(pc_plus4F), .validF(validF)
  );

  always #5 clk = ~clk;

  // Outstanding memory requests tagged with the control-flow epoch they were issued in.
  typedef struct { logic [31:0] addr; int epoch; } req_t;
  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  typedef struct { bit gnt; bit stall; bit req; logic [31:0] addr; bit valid; logic [31:0] pc; } vec_t;

  req_t        mq[$];
  ent_t        fq[$];
  int          epoch;
  logic [31:0] fa;
  int          rv_prob;
  int          tests;
  int          failed;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    fq.delete();
    epoch = 0;
    fa    = RESET_PC;
  endtask

  task automatic do_reset(input bit immediate);
    if (!immediate) @(negedge clk);
    rst = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    StallF = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #1;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(validF), 32'h0);
    chk("rst_instr", instrF, NOP);
    chk("rst_pc", pcF, 32'h0);
    chk("rst_pc4", pc_plus4F, 32'h4);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  // One clock: drive inputs at negedge, compare against the model, then advance the model.
  task automatic run_cycle(input bit g, input bit st, input bit rd, input logic [31:0] tgt,
                           input bit force_rv, input bit stray);
    bit          exp_req;
    logic [31:0] ep;
    @(negedge clk);
    imem_gnt = g; StallF = st; redirect = rd; redirect_pc = tgt;
    if (mq.size() > 0) begin
      imem_rvalid = force_rv || ($urandom_range(0, 99) < rv_prob);
      imem_rdata  = mq[0].addr | 32'h13;
    end else begin
      imem_rvalid = stray;
      imem_rdata  = $urandom;
    end
    #1;
    exp_req = !rd && ((fq.size() + mq.size()) < DEPTH);
    ep      = (fq.size() > 0) ? fq[0].pc : 32'h0;
    chk("model_req", 32'(imem_req), 32'(exp_req));
    chk("model_addr", imem_addr, fa);
    chk("model_valid", 32'(validF), 32'(fq.size() > 0));
    chk("model_pcF", pcF, ep);
    chk("model_instrF", instrF, (fq.size() > 0) ? fq[0].instr : NOP);
    chk("model_pc_plus4F", pc_plus4F, ep + 32'd4);
    if (rd) begin
      if (imem_rvalid && mq.size() > 0) void'(mq.pop_front());
      fq.delete();
      epoch++;
      fa = tgt;
    end else begin
      if (fq.size() > 0 && !st) void'(fq.pop_front());
      if (imem_rvalid && mq.size() > 0) begin
        req_t r;
        r = mq.pop_front();
        if (r.epoch == epoch) fq.push_back('{imem_rdata, r.addr});
      end
      if (imem_req && g) begin
        mq.push_back('{imem_addr, epoch});
        fa = fa + 32'd4;
      end
    end
  endtask

  task automatic wait_valid(input logic [31:0] exp_pc, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      run_cycle(1, 0, 0, 32'h0, 0, 0);
      if (validF) seen = 1'b1;
    end
    chk({name, "_seen"}, 32'(seen), 32'h1);
    if (seen) begin
      chk(name, pcF, exp_pc);
      chk({name, "_instr"}, instrF, exp_pc | 32'h13);
    end
  endtask

  vec_t tbl[17];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          seen;
    int          nvalid;
    bit          rd;
    logic [31:0] tgt;
    tests = 0; failed = 0; rv_prob = 100;
    model_reset();

    // Zero-wait memory, then a 4-cycle stall that fills the FIFO.
    tbl[0]  = '{1, 0, 1, 32'd0,  0, 32'd0};
    tbl[1]  = '{1, 0, 1, 32'd4,  0, 32'd0};
    tbl[2]  = '{1, 0, 0, 32'd8,  1, 32'd0};
    tbl[3]  = '{1, 0, 1, 32'd8,  1, 32'd4};
    tbl[4]  = '{1, 0, 1, 32'd12, 0, 32'd0};
    tbl[5]  = '{1, 0, 0, 32'd16, 1, 32'd8};
    tbl[6]  = '{1, 0, 1, 32'd16, 1, 32'd12};
    tbl[7]  = '{1, 0, 1, 32'd20, 0, 32'd0};
    tbl[8]  = '{1, 0, 0, 32'd24, 1, 32'd16};
    tbl[9]  = '{1, 1, 1, 32'd24, 1, 32'd20};
    tbl[10] = '{1, 1, 0, 32'd28, 1, 32'd20};
    tbl[11] = '{1, 1, 0, 32'd28, 1, 32'd20};
    tbl[12] = '{1, 1, 0, 32'd28, 1, 32'd20};
    tbl[13] = '{1, 0, 0, 32'd28, 1, 32'd20};
    tbl[14] = '{1, 0, 1, 32'd28, 1, 32'd24};
    tbl[15] = '{1, 0, 1, 32'd32, 0, 32'd0};
    tbl[16] = '{1, 0, 0, 32'd36, 1, 32'd28};

    do_reset(0);
    rv_prob = 100;
    for (int i = 0; i < 17; i++) begin
      run_cycle(tbl[i].gnt, tbl[i].stall, 0, 32'h0, 0, 0);
      chk($sformatf("tbl%0d_req", i), 32'(imem_req), 32'(tbl[i].req));
      chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), 32'(validF), 32'(tbl[i].valid));
      chk($sformatf("tbl%0d_pc", i), pcF, tbl[i].pc);
      chk($sformatf("tbl%0d_instr", i), instrF, tbl[i].valid ? (tbl[i].pc | 32'h13) : NOP);
    end

    // Grant withheld for three cycles: address holds, FIFO drains to NOP.
    do_reset(0);
    rv_prob = 100;
    for (int i = 0; i < 3; i++) run_cycle(1, 0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      run_cycle(0, 0, 0, 32'h0, 0, 0);
      chk("nognt_addr", imem_addr, 32'h8);
      chk("nognt_req", 32'(imem_req), 32'h1);
      if (i > 0) begin
        chk("nognt_valid", 32'(validF), 32'h0);
        chk("nognt_instr", instrF, NOP);
      end
    end
    run_cycle(1, 0, 0, 32'h0, 0, 0);
    chk("gnt_addr", imem_addr, 32'h8);
    run_cycle(1, 0, 0, 32'h0, 0, 0);
    chk("gnt_next_addr", imem_addr, 32'hC);

    // Redirect with two requests outstanding.
    do_reset(0);
    rv_prob = 0;
    run_cycle(1, 0, 0, 32'h0, 0, 0);
    run_cycle(1, 0, 0, 32'h0, 0, 0);
    run_cycle(1, 0, 1, 32'h100, 0, 0);
    chk("redirA_req_low", 32'(imem_req), 32'h0);
    rv_prob = 100;
    seen = 1'b0; nvalid = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      run_cycle(1, 0, 0, 32'h0, 0, 0);
      if (validF) nvalid++;
      if (imem_req) begin
        seen = 1'b1;
        chk("redirA_first_addr", imem_addr, 32'h100);
      end
    end
    chk("redirA_req_seen", 32'(seen), 32'h1);
    chk("redirA_no_stale", 32'(nvalid), 32'h0);
    wait_valid(32'h100, "redirA_first_pc");

    // Redirect coinciding with a response while two are outstanding.
    do_reset(0);
    rv_prob = 0;
    run_cycle(1, 0, 0, 32'h0, 0, 0);
    run_cycle(1, 0, 0, 32'h0, 0, 0);
    run_cycle(1, 0, 1, 32'h200, 1, 0);
    chk("redirB_req_low", 32'(imem_req), 32'h0);
    rv_prob = 100;
    run_cycle(1, 0, 0, 32'h0, 0, 0);
    chk("redirB_req", 32'(imem_req), 32'h1);
    chk("redirB_addr", imem_addr, 32'h200);
    chk("redirB_valid", 32'(validF), 32'h0);
    wait_valid(32'h200, "redirB_first_pc");

    // Stray response with nothing outstanding must not underflow the credit count.
    do_reset(0);
    rv_prob = 0;
    run_cycle(0, 0, 0, 32'h0, 0, 1);
    run_cycle(0, 0, 0, 32'h0, 0, 0);
    chk("stray_req", 32'(imem_req), 32'h1);
    rv_prob = 100;
    wait_valid(32'h0, "stray_then_fetch");

    // Reset while the FIFO holds an entry and a request is outstanding.
    do_reset(0);
    rv_prob = 100;
    for (int i = 0; i < 3; i++) run_cycle(1, 0, 0, 32'h0, 0, 0);
    chk("midrst_pre_valid", 32'(validF), 32'h1);
    do_reset(1);
    run_cycle(1, 0, 0, 32'h0, 0, 0);
    chk("midrst_restart_addr", imem_addr, RESET_PC);
    chk("midrst_restart_req", 32'(imem_req), 32'h1);

    // Randomized traffic against the reference model.
    do_reset(0);
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) rv_prob = $urandom_range(20, 100);
      if (i % 1500 == 1499) do_reset(0);
      rd  = ($urandom_range(0, 99) < 4);
      tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
      run_cycle($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 30, rd, tgt, 0,
                $urandom_range(0, 99) < 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
